data_sram_ctrl: RTL

//  Initiator side of the data-SRAM strobe interface. Accepts single-beat load/store requests from the
//  CPU core over a ready/req/done handshake. Generates the WD/RD/ADDR/DIN/CS_D sequence that the

---
 rtl/data_sram_ctrl_pkg.sv | 27 ++
 rtl/data_sram_ctrl_if.sv | 41 ++++
 rtl/data_sram_ctrl_cycle_timer.sv | 42 ++++
 rtl/data_sram_ctrl.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/data_sram_ctrl_pkg.sv
// data_sram_ctrl_pkg
//   Definitions shared by the data-SRAM controller, its bus interface and its
//   timer: FSM state encoding, default SRAM geometry and the timer width helper.
//   No ports (package).

package data_sram_ctrl_pkg;

  // Geometry defaults shared with the data SRAM.
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } state_e;

  // One timer serves both the setup and the strobe phase, so it is sized for
  // the longer of the two.
  function automatic int cnt_width(input int setup_cyc, input int strobe_cyc);
    int m;
    m = (setup_cyc > strobe_cyc) ? setup_cyc : strobe_cyc;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/data_sram_ctrl_if.sv
// data_sram_ctrl_if
//   Bundles the core-side request handshake and the SRAM strobe bus of the
//   data-SRAM controller.
//   Core side : req, we, addr, wdata (to controller); ready, done, rdata (from it)
//   SRAM side : WD, RD, CS_D, ADDR, DIN (from controller); DOUT (to it)
//   Modports  : slave  - the controller
//               master - its environment (core plus SRAM)

interface data_sram_ctrl_if
  import data_sram_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ready;
  logic              done;
  logic [DATA_W-1:0] rdata;

  logic              WD;
  logic              RD;
  logic              CS_D;
  logic [ADDR_W-1:0] ADDR;
  logic [DATA_W-1:0] DIN;
  logic [DATA_W-1:0] DOUT;

  modport slave (
    input  req, we, addr, wdata, DOUT,
    output ready, done, rdata, WD, RD, CS_D, ADDR, DIN
  );

  modport master (
    output req, we, addr, wdata, DOUT,
    input  ready, done, rdata, WD, RD, CS_D, ADDR, DIN
  );

endinterface

// File: rtl/data_sram_ctrl_cycle_timer.sv
// data_sram_ctrl_cycle_timer
//   Loadable down-counter with terminal-count flag. Loading N gives N+1 cycles
//   until tc_o is seen by the FSM (tc_o is high while the count is zero).
//   clk_i      : system clock
//   rst_i      : synchronous active-high reset, count -> 0
//   load_i     : load load_val_i this edge (overrides decrement)
//   load_val_i : value to load
//   tc_o       : terminal count, high while the count is zero

module data_sram_ctrl_cycle_timer #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/data_sram_ctrl.sv
// data_sram_ctrl
//   Initiator for the data-SRAM strobe interface. Takes single-beat load/store
//   requests from the core memory stage and drives the WD/RD/ADDR/DIN/CS_D
//   sequence; the SRAM acts on the CS_D falling edge. All outputs registered.
//   clk_i  : system clock
//   rst_i  : synchronous active-high reset
//   bus_if : slave view of data_sram_ctrl_if (core handshake + SRAM bus)
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | ready=1, CS_D=1, WD=RD=0; a req is latched and accepted
//   SETUP  | CS_D=1, controls stable, SETUP_CYC cycles
//   STROBE | CS_D=0, STROBE_CYC cycles; load data captured on exit edge
//   HOLD   | CS_D=1, controls still held, done=1 for this one cycle

module data_sram_ctrl
  import data_sram_ctrl_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 1
) (
  input logic              clk_i,
  input logic              rst_i,
  data_sram_ctrl_if.slave  bus_if
);

  localparam int CNT_W = cnt_width(SETUP_CYC, STROBE_CYC);

  // The timer reports terminal count while at zero, so loading N-1 on
  // phase entry yields exactly N cycles in that phase.
  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);

  state_e state_q, state_d;

  logic              ready_q, ready_d;
  logic              done_q,  done_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              wd_q,    wd_d;
  logic              rd_q,    rd_d;
  logic              cs_d_q,  cs_d_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [DATA_W-1:0] din_q,   din_d;

  logic              tmr_load;
  logic [CNT_W-1:0]  tmr_val;
  logic              tmr_tc;

  data_sram_ctrl_cycle_timer #(
    .W (CNT_W)
  ) u_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .tc_o       (tmr_tc)
  );

  always_comb begin
    state_d  = state_q;
    ready_d  = ready_q;
    done_d   = 1'b0;
    rdata_d  = rdata_q;
    wd_d     = wd_q;
    rd_d     = rd_q;
    cs_d_d   = cs_d_q;
    addr_d   = addr_q;
    din_d    = din_q;
    tmr_load = 1'b0;
    tmr_val  = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus_if.req) begin
          state_d  = ST_SETUP;
          ready_d  = 1'b0;
          addr_d   = bus_if.addr;
          din_d    = bus_if.wdata;
          wd_d     = bus_if.we;
          rd_d     = ~bus_if.we;
          tmr_load = 1'b1;
          tmr_val  = SETUP_LD;
        end
      end

      ST_SETUP: begin
        if (tmr_tc) begin
          state_d  = ST_STROBE;
          cs_d_d   = 1'b0;
          tmr_load = 1'b1;
          tmr_val  = STROBE_LD;
        end
      end

      ST_STROBE: begin
        if (tmr_tc) begin
          state_d  = ST_HOLD;
          cs_d_d   = 1'b1;
          done_d   = 1'b1;
          tmr_load = 1'b1;
          // DOUT was updated by the SRAM at the CS_D fall and is stable here.
          if (rd_q) begin
            rdata_d = bus_if.DOUT;
          end
        end
      end

      ST_HOLD: begin
        // ADDR/DIN deliberately keep their values into IDLE.
        state_d  = ST_IDLE;
        ready_d  = 1'b1;
        wd_d     = 1'b0;
        rd_d     = 1'b0;
        tmr_load = 1'b1;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      rdata_q <= '0;
      wd_q    <= 1'b0;
      rd_q    <= 1'b0;
      cs_d_q  <= 1'b1;
      addr_q  <= '0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
      wd_q    <= wd_d;
      rd_q    <= rd_d;
      cs_d_q  <= cs_d_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
    end
  end

  assign bus_if.ready = ready_q;
  assign bus_if.done  = done_q;
  assign bus_if.rdata = rdata_q;
  assign bus_if.WD    = wd_q;
  assign bus_if.RD    = rd_q;
  assign bus_if.CS_D  = cs_d_q;
  assign bus_if.ADDR  = addr_q;
  assign bus_if.DIN   = din_q;

endmodule
